// File: rtl/uart_rx_pkg.sv
// Shared configuration for the UART receiver: baud timing, frame length and FSM state encodings.
// The baud values match those used by the transmitter on the same link.
package uart_rx_pkg;

`ifdef SIM
  localparam int BAUD_END_DEF = 56;
`else
  localparam int BAUD_END_DEF = 5207;
`endif

  localparam logic [3:0] BIT_END = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_DATA  = 2'b10,
    S_STOP  = 2'b11
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: synchronises rx, detects the start edge, samples mid-bit
// and delivers each byte with a one-cycle valid strobe (or a one-cycle framing-error strobe).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_END = BAUD_END_DEF,
  parameter int BAUD_MID = BAUD_END / 2
) (
  input  logic       sys_clk_50M,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [12:0] BAUD_END_C = 13'(BAUD_END);
  localparam logic [12:0] BAUD_MID_C = 13'(BAUD_MID);

  logic [2:0]  rx_sync_q;
  rx_state_e   state_q;
  logic [12:0] baud_cnt_q;
  logic [12:0] baud_cnt_d;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  bit_cnt_d;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        frame_err_q;
  logic        rx_busy_q;
  logic        fall_s;
  logic        strobe_s;
  logic        wrap_s;
  logic        bit_s;

  assign baud_cnt_d = baud_cnt_q + 13'd1;
  assign bit_cnt_d  = bit_cnt_q + 4'd1;
  assign fall_s     = rx_sync_q[2] & ~rx_sync_q[1];
  assign bit_s      = rx_sync_q[1];
  assign strobe_s   = (baud_cnt_q == BAUD_MID_C) && (state_q != S_IDLE);
  assign wrap_s     = (baud_cnt_q == BAUD_END_C);

  // Synchroniser resets high so reset release never looks like a start edge.
  always_ff @(posedge sys_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= 3'b111;
    end else begin
      rx_sync_q <= {rx_sync_q[1:0], rx};
    end
  end

  // Receive FSM with bit/baud counters and registered output strobes.
  always_ff @(posedge sys_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= 13'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          baud_cnt_q <= 13'd0;
          bit_cnt_q  <= 4'd0;
          if (fall_s) begin
            state_q   <= S_START;
            rx_busy_q <= 1'b1;
          end else begin
            rx_busy_q <= 1'b0;
          end
        end
        S_START: begin
          if (strobe_s && bit_s) begin
            state_q    <= S_IDLE;
            rx_busy_q  <= 1'b0;
            baud_cnt_q <= 13'd0;
          end else if (wrap_s) begin
            state_q    <= S_DATA;
            baud_cnt_q <= 13'd0;
            bit_cnt_q  <= bit_cnt_d;
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end
        S_DATA: begin
          if (strobe_s) begin
            shift_q <= {bit_s, shift_q[7:1]};
          end else begin
            shift_q <= shift_q;
          end
          if (wrap_s) begin
            baud_cnt_q <= 13'd0;
            bit_cnt_q  <= bit_cnt_d;
            if (bit_cnt_q == (BIT_END - 4'd1)) begin
              state_q <= S_STOP;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end
        S_STOP: begin
          // Leave at mid-stop so a zero-gap next start edge is still caught.
          if (strobe_s) begin
            state_q    <= S_IDLE;
            rx_busy_q  <= 1'b0;
            baud_cnt_q <= 13'd0;
            if (bit_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_d;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          rx_busy_q  <= 1'b0;
          baud_cnt_q <= 13'd0;
          bit_cnt_q  <= 4'd0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_END=56: table of frames plus corner-case sequences
// (zero-gap frames, glitch, break after framing error, reset mid-frame).
module tb_uart_rx;

  localparam int BIT = 57;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int total;
  int bad;

  int         valid_cnt;
  int         err_cnt;
  logic [7:0] got_q[$];
  logic       prev_valid;
  logic       both_seen;
  logic       long_seen;

  uart_rx #(.BAUD_END(56)) dut (
    .sys_clk_50M(clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    valid_cnt  = 0;
    err_cnt    = 0;
    prev_valid = 1'b0;
    both_seen  = 1'b0;
    long_seen  = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        valid_cnt <= valid_cnt + 1;
        got_q.push_back(rx_data);
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (rx_valid && frame_err) both_seen <= 1'b1;
      if (rx_valid && prev_valid) long_seen <= 1'b1;
      prev_valid <= rx_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] d, input logic stop, input int clks);
    rx = 1'b0;
    wait_clks(clks);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(clks);
    end
    rx = stop;
    wait_clks(clks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int clks);
    send_raw(d, stop, clks);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bit_clks;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int v0, e0, n0, n;
    logic [7:0] b0, b1;

    total = 0;
    bad   = 0;
    vecs[0] = '{8'h55, 1'b1, BIT,     1, 0, 8'h55};
    vecs[1] = '{8'h00, 1'b1, BIT,     1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, BIT,     1, 0, 8'hFF};
    vecs[3] = '{8'h5A, 1'b1, BIT + 1, 1, 0, 8'h5A};
    vecs[4] = '{8'hA5, 1'b1, BIT - 1, 1, 0, 8'hA5};
    vecs[5] = '{8'h3C, 1'b0, BIT,     0, 1, 8'hA5};
    vecs[6] = '{8'h81, 1'b1, BIT,     1, 0, 8'h81};

    rx    = 1'b1;
    rst_n = 1'b0;
    wait_clks(5);
    check("rst_data", int'(rx_data), 8'h00);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_err", int'(frame_err), 0);
    check("rst_busy", int'(rx_busy), 0);
    rst_n = 1'b1;
    wait_clks(20);
    check("post_rst_busy", int'(rx_busy), 0);

    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_clks);
      wait_clks(40);
      check($sformatf("v%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("v%0d_data", i), int'(rx_data), int'(vecs[i].exp_data));
      check($sformatf("v%0d_busy", i), int'(rx_busy), 0);
    end

    // Two frames with zero idle gap.
    n0 = got_q.size();
    send_frame(8'hA3, 1'b1, BIT);
    send_frame(8'h0F, 1'b1, BIT);
    wait_clks(40);
    check("b2b_count", got_q.size() - n0, 2);
    b0 = (got_q.size() > n0) ? got_q[n0] : 8'h00;
    b1 = (got_q.size() > n0 + 1) ? got_q[n0 + 1] : 8'h00;
    check("b2b_first", int'(b0), 8'hA3);
    check("b2b_second", int'(b1), 8'h0F);

    // Short low glitch: false start, busy drops around the mid-bit sample.
    v0 = valid_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    wait_clks(10);
    rx = 1'b1;
    check("glitch_busy_high", int'(rx_busy), 1);
    n = 0;
    while (rx_busy && n < 100) begin
      wait_clks(1);
      n++;
    end
    check("glitch_busy_fall", int'(n >= 18 && n <= 26), 1);
    wait_clks(40);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_data", int'(rx_data), 8'h0F);

    // Bad stop bit followed by a held-low break line.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_raw(8'hFF, 1'b0, BIT);
    wait_clks(300);
    check("break_busy", int'(rx_busy), 0);
    wait_clks(200);
    rx = 1'b1;
    wait_clks(20);
    check("break_err", err_cnt - e0, 1);
    check("break_valid", valid_cnt - v0, 0);
    check("break_data", int'(rx_data), 8'h0F);
    v0 = valid_cnt;
    send_frame(8'h81, 1'b1, BIT);
    wait_clks(40);
    check("after_break_valid", valid_cnt - v0, 1);
    check("after_break_data", int'(rx_data), 8'h81);

    // Reset during data bit 4 of 0xC6.
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC6 >> i) & 8'h01;
      wait_clks(BIT);
    end
    rx = 1'b0;
    wait_clks(20);
    check("mid_busy", int'(rx_busy), 1);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check("mid_rst_data", int'(rx_data), 8'h00);
    check("mid_rst_valid", int'(rx_valid), 0);
    check("mid_rst_err", int'(frame_err), 0);
    check("mid_rst_busy", int'(rx_busy), 0);
    wait_clks(4);
    rst_n = 1'b1;
    v0 = valid_cnt;
    e0 = err_cnt;
    wait_clks(100);
    check("post_mid_valid", valid_cnt - v0, 0);
    check("post_mid_err", err_cnt - e0, 0);
    check("post_mid_data", int'(rx_data), 8'h00);
    send_frame(8'h3C, 1'b1, BIT);
    wait_clks(40);
    check("post_mid_frame_valid", valid_cnt - v0, 1);
    check("post_mid_frame_data", int'(rx_data), 8'h3C);

    check("never_both", int'(both_seen), 0);
    check("pulse_width", int'(long_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
